// File: rtl/fwd_result_if.sv
// Bundle between the E/M/W result tracker and its neighbours: pipe control, new entries,
// late stage results, D-stage operand lookup and the regfile write port.
interface fwd_result_if #(
  parameter int WIDTH  = 32,
  parameter int REGW   = 5,
  parameter int STAGES = 3,
  parameter int SW     = 2
);
  logic                    adv;
  logic                    flush;
  logic                    in_valid;
  logic [REGW-1:0]         in_dst;
  logic                    in_is_link;
  logic [WIDTH-1:0]        in_pc8;
  logic [SW-1:0]           in_rdy_stage;
  logic [STAGES*WIDTH-1:0] stg_res;
  logic [REGW-1:0]         src0;
  logic [REGW-1:0]         src1;
  logic [WIDTH-1:0]        rd0;
  logic [WIDTH-1:0]        rd1;
  logic [WIDTH-1:0]        fwd0;
  logic [WIDTH-1:0]        fwd1;
  logic                    pend0;
  logic                    pend1;
  logic                    wb_valid;
  logic [REGW-1:0]         wb_dst;
  logic [WIDTH-1:0]        wb_data;

  modport master (
    output adv, flush, in_valid, in_dst, in_is_link, in_pc8, in_rdy_stage, stg_res,
    output src0, src1, rd0, rd1,
    input  fwd0, fwd1, pend0, pend1, wb_valid, wb_dst, wb_data
  );

  modport slave (
    input  adv, flush, in_valid, in_dst, in_is_link, in_pc8, in_rdy_stage, stg_res,
    input  src0, src1, rd0, rd1,
    output fwd0, fwd1, pend0, pend1, wb_valid, wb_dst, wb_data
  );
endinterface

// File: rtl/fwd_result_pipe.sv
// Result-tracking pipeline for E->M->W: captures late results as entries move on, forwards
// the youngest matching producer to D and writes the regfile from the last stage.
module fwd_result_pipe #(
  parameter int WIDTH  = 32,
  parameter int REGW   = 5,
  parameter int STAGES = 3,
  parameter int SW     = 2,
  parameter int FWD_EN = 1
) (
  input logic         clk,
  input logic         reset,
  fwd_result_if.slave bus
);
  localparam int            LAST     = STAGES - 1;
  localparam logic [SW-1:0] LAST_IDX = SW'(LAST);

  logic             valid_reg [STAGES];
  logic             ready_reg [STAGES];
  logic [REGW-1:0]  dst_reg   [STAGES];
  logic [SW-1:0]    rdy_reg   [STAGES];
  logic [WIDTH-1:0] data_reg  [STAGES];

  logic             ready_eff [STAGES];
  logic [WIDTH-1:0] data_eff  [STAGES];
  logic [SW-1:0]    in_rdy_clamped;

  // Out-of-range producer stages collapse onto the last stage so they still resolve.
  assign in_rdy_clamped = (bus.in_rdy_stage > LAST_IDX) ? LAST_IDX : bus.in_rdy_stage;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= 1'b0;
        ready_reg[k] <= 1'b0;
        dst_reg[k]   <= '0;
        rdy_reg[k]   <= '0;
        data_reg[k]  <= '0;
      end
    end else if (bus.flush) begin
      for (int k = 0; k < STAGES; k++) valid_reg[k] <= 1'b0;
    end else if (bus.adv) begin
      valid_reg[0] <= bus.in_valid;
      dst_reg[0]   <= bus.in_dst;
      rdy_reg[0]   <= in_rdy_clamped;
      ready_reg[0] <= bus.in_is_link;
      data_reg[0]  <= bus.in_pc8;
      for (int k = 1; k < STAGES; k++) begin
        valid_reg[k] <= valid_reg[k-1];
        dst_reg[k]   <= dst_reg[k-1];
        rdy_reg[k]   <= rdy_reg[k-1];
        // A producer leaving its result stage picks up that stage's result bus.
        if (!ready_reg[k-1] && (rdy_reg[k-1] == SW'(k-1))) begin
          ready_reg[k] <= 1'b1;
          data_reg[k]  <= bus.stg_res[(k-1)*WIDTH +: WIDTH];
        end else begin
          ready_reg[k] <= ready_reg[k-1];
          data_reg[k]  <= data_reg[k-1];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_eff
      if (gi == LAST) begin : g_last
        assign ready_eff[gi] = ready_reg[gi] | (rdy_reg[gi] == LAST_IDX);
        assign data_eff[gi]  = ready_reg[gi] ? data_reg[gi] : bus.stg_res[LAST*WIDTH +: WIDTH];
      end else begin : g_mid
        assign ready_eff[gi] = ready_reg[gi];
        assign data_eff[gi]  = data_reg[gi];
      end
    end
  endgenerate

  assign bus.wb_valid = bus.adv & valid_reg[LAST] & (dst_reg[LAST] != '0);
  assign bus.wb_dst   = dst_reg[LAST];
  assign bus.wb_data  = data_eff[LAST];

  logic [REGW-1:0]  src_a  [2];
  logic [WIDTH-1:0] rd_a   [2];
  logic [WIDTH-1:0] fwd_a  [2];
  logic             pend_a [2];

  assign src_a[0] = bus.src0;
  assign src_a[1] = bus.src1;
  assign rd_a[0]  = bus.rd0;
  assign rd_a[1]  = bus.rd1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_op
      logic hit;
      // Stage 0 is searched first, so the youngest producer of a register decides.
      always_comb begin
        fwd_a[gi]  = rd_a[gi];
        pend_a[gi] = 1'b0;
        hit        = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
          if (!hit && valid_reg[k] && (dst_reg[k] == src_a[gi]) && (src_a[gi] != '0)) begin
            hit = 1'b1;
            if (FWD_EN == 0 || !ready_eff[k]) pend_a[gi] = 1'b1;
            else fwd_a[gi] = data_eff[k];
          end
        end
      end
    end
  endgenerate

  assign bus.fwd0  = fwd_a[0];
  assign bus.fwd1  = fwd_a[1];
  assign bus.pend0 = pend_a[0];
  assign bus.pend1 = pend_a[1];
endmodule

// File: tb/tb_fwd_result_pipe.sv
// Directed bench for fwd_result_pipe: reset, ALU/load/link latency, youngest-wins,
// $0 and hold, flush and mid-stream reset.
module tb_fwd_result_pipe;
  localparam int WIDTH = 32;
  localparam int REGW = 5;
  localparam int STAGES = 3;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  fwd_result_if #(.WIDTH(WIDTH), .REGW(REGW), .STAGES(STAGES), .SW(SW)) bus ();

  fwd_result_pipe #(.WIDTH(WIDTH), .REGW(REGW), .STAGES(STAGES), .SW(SW), .FWD_EN(1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d adv=%0b flush=%0b in_valid=%0b in_dst=%0d wb_valid=%0b wb_dst=%0d wb_data=%h",
             cyc, bus.adv, bus.flush, bus.in_valid, bus.in_dst, bus.wb_valid, bus.wb_dst, bus.wb_data);
  endtask

  task automatic idle();
    bus.adv = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_dst = '0;
    bus.in_is_link = 1'b0;
    bus.in_pc8 = '0;
    bus.in_rdy_stage = '0;
    bus.stg_res = '0;
  endtask

  task automatic enter(input logic [4:0] dst, input logic link, input logic [31:0] pc8,
                       input logic [1:0] rdy);
    bus.in_valid = 1'b1;
    bus.in_dst = dst;
    bus.in_is_link = link;
    bus.in_pc8 = pc8;
    bus.in_rdy_stage = rdy;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.adv = 1'($urandom);
      bus.flush = 1'($urandom);
      bus.in_valid = 1'b1;
      bus.in_dst = 5'($urandom_range(1, 31));
      bus.in_is_link = 1'b1;
      bus.in_pc8 = $urandom;
      bus.in_rdy_stage = 2'($urandom);
      bus.stg_res = {$urandom, $urandom, $urandom};
      step();
    end
    bus.src0 = 5'd7; bus.src1 = 5'd19;
    bus.rd0 = 32'hA5A5_0001; bus.rd1 = 32'h5A5A_0002;
    bus.adv = 1'b1;
    bus.stg_res = '0;
    #1;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", bus.wb_valid); end
    checks++; if (bus.wb_dst !== 5'd0) begin errors++; $display("FAIL reset_wb_dst got %0d exp 0", bus.wb_dst); end
    checks++; if (bus.wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h exp 0", bus.wb_data); end
    checks++; if (bus.pend0 !== 1'b0 || bus.pend1 !== 1'b0) begin errors++; $display("FAIL reset_pend got %b%b exp 00", bus.pend0, bus.pend1); end
    checks++; if (bus.fwd0 !== 32'hA5A5_0001) begin errors++; $display("FAIL reset_fwd0 got %h exp a5a50001", bus.fwd0); end
    checks++; if (bus.fwd1 !== 32'h5A5A_0002) begin errors++; $display("FAIL reset_fwd1 got %h exp 5a5a0002", bus.fwd1); end
    idle();
    bus.adv = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    bus.adv = 1'b1;
  endtask

  task automatic test_alu_chain();
    bus.src0 = 5'd8; bus.rd0 = 32'hDEAD_0008;
    enter(5'd8, 1'b0, 32'h0, 2'd0);
    step();
    idle();
    bus.stg_res = {32'h0, 32'h0, 32'h1234};
    #1;
    checks++; if (bus.pend0 !== 1'b1) begin errors++; $display("FAIL alu_pend_e got %b exp 1", bus.pend0); end
    step();
    bus.stg_res = '0;
    #1;
    checks++; if (bus.fwd0 !== 32'h1234 || bus.pend0 !== 1'b0) begin errors++; $display("FAIL alu_fwd_m got %h/%b exp 1234/0", bus.fwd0, bus.pend0); end
    step();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_dst !== 5'd8 || bus.wb_data !== 32'h1234) begin
      errors++; $display("FAIL alu_wb got %b/%0d/%h exp 1/8/1234", bus.wb_valid, bus.wb_dst, bus.wb_data); end
    checks++; if (bus.fwd0 !== 32'h1234) begin errors++; $display("FAIL alu_fwd_w got %h exp 1234", bus.fwd0); end
    step();
    checks++; if (bus.wb_valid !== 1'b0 || bus.fwd0 !== 32'hDEAD_0008) begin
      errors++; $display("FAIL alu_retired got %b/%h exp 0/dead0008", bus.wb_valid, bus.fwd0); end
  endtask

  task automatic test_load_use();
    bus.src1 = 5'd9; bus.rd1 = 32'h0000_0BAD;
    enter(5'd9, 1'b0, 32'h0, 2'd1);
    step();
    idle();
    checks++; if (bus.pend1 !== 1'b1) begin errors++; $display("FAIL load_pend_e got %b exp 1", bus.pend1); end
    step();
    checks++; if (bus.pend1 !== 1'b1) begin errors++; $display("FAIL load_pend_m got %b exp 1", bus.pend1); end
    bus.stg_res = {32'h0, 32'hCAFE, 32'h0};
    #1;
    checks++; if (bus.pend1 !== 1'b1) begin errors++; $display("FAIL load_pend_nocomb got %b exp 1", bus.pend1); end
    step();
    bus.stg_res = '0;
    #1;
    checks++; if (bus.pend1 !== 1'b0 || bus.fwd1 !== 32'hCAFE) begin errors++; $display("FAIL load_fwd got %b/%h exp 0/cafe", bus.pend1, bus.fwd1); end
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hCAFE) begin errors++; $display("FAIL load_wb got %b/%h exp 1/cafe", bus.wb_valid, bus.wb_data); end
    step();
    // rdy_stage 3 is clamped to the last stage and resolved from stg_res[2] there
    bus.src0 = 5'd10; bus.rd0 = 32'h1;
    enter(5'd10, 1'b0, 32'h0, 2'd3);
    step();
    idle();
    step();
    checks++; if (bus.pend0 !== 1'b1) begin errors++; $display("FAIL clamp_pend_m got %b exp 1", bus.pend0); end
    step();
    bus.stg_res = {32'h77, 32'h0, 32'h0};
    #1;
    checks++; if (bus.pend0 !== 1'b0 || bus.fwd0 !== 32'h77 || bus.wb_data !== 32'h77) begin
      errors++; $display("FAIL clamp_last got %b/%h/%h exp 0/77/77", bus.pend0, bus.fwd0, bus.wb_data); end
    bus.stg_res = '0;
    step();
  endtask

  task automatic test_link_youngest();
    bus.src0 = 5'd31; bus.rd0 = 32'hFFFF_0031;
    enter(5'd31, 1'b1, 32'h3008, 2'd0);
    step();
    checks++; if (bus.fwd0 !== 32'h3008 || bus.pend0 !== 1'b0) begin errors++; $display("FAIL link_fwd got %h/%b exp 3008/0", bus.fwd0, bus.pend0); end
    enter(5'd31, 1'b0, 32'h0, 2'd0);
    step();
    idle();
    checks++; if (bus.pend0 !== 1'b1) begin errors++; $display("FAIL young_pend got %b exp 1", bus.pend0); end
    bus.stg_res = {32'h0, 32'h0, 32'h5};
    step();
    bus.stg_res = '0;
    #1;
    checks++; if (bus.fwd0 !== 32'h5 || bus.pend0 !== 1'b0) begin errors++; $display("FAIL young_fwd got %h/%b exp 5/0", bus.fwd0, bus.pend0); end
    step();
    step();
  endtask

  task automatic test_zero_hold();
    bus.src0 = 5'd0; bus.rd0 = 32'h4444;
    enter(5'd0, 1'b1, 32'h99, 2'd0);
    step();
    idle();
    checks++; if (bus.fwd0 !== 32'h4444 || bus.pend0 !== 1'b0) begin errors++; $display("FAIL zero_fwd got %h/%b exp 4444/0", bus.fwd0, bus.pend0); end
    step();
    step();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL zero_wb got %b exp 0", bus.wb_valid); end
    bus.src1 = 5'd12; bus.rd1 = 32'h0;
    enter(5'd12, 1'b1, 32'h1200, 2'd0);
    step();
    idle();
    step();
    step();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_dst !== 5'd12) begin errors++; $display("FAIL hold_pre_wb got %b/%0d exp 1/12", bus.wb_valid, bus.wb_dst); end
    bus.adv = 1'b0;
    enter(5'd13, 1'b1, 32'h1300, 2'd0);
    bus.src0 = 5'd13; bus.rd0 = 32'h1313;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.wb_valid !== 1'b0 || bus.fwd1 !== 32'h1200) begin
        errors++; $display("FAIL hold_keep got %b/%h exp 0/1200", bus.wb_valid, bus.fwd1); end
    end
    checks++; if (bus.fwd0 !== 32'h1313) begin errors++; $display("FAIL hold_noentry got %h exp 1313", bus.fwd0); end
    idle();
    #1;
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h1200) begin errors++; $display("FAIL hold_release got %b/%h exp 1/1200", bus.wb_valid, bus.wb_data); end
    step();
  endtask

  task automatic test_flush_reset();
    enter(5'd1, 1'b1, 32'h11, 2'd0);
    step();
    enter(5'd2, 1'b1, 32'h22, 2'd0);
    step();
    enter(5'd3, 1'b0, 32'h0, 2'd1);
    step();
    bus.src0 = 5'd3; bus.rd0 = 32'hAAAA;
    bus.src1 = 5'd1; bus.rd1 = 32'hBBBB;
    enter(5'd5, 1'b1, 32'h55, 2'd0);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.pend0 !== 1'b1 || bus.fwd1 !== 32'h11) begin errors++; $display("FAIL full_pre got %b/%h exp 1/11", bus.pend0, bus.fwd1); end
    step();
    idle();
    #1;
    checks++; if (bus.pend0 !== 1'b0 || bus.fwd0 !== 32'hAAAA || bus.fwd1 !== 32'hBBBB || bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_clear got %b/%h/%h/%b exp 0/aaaa/bbbb/0", bus.pend0, bus.fwd0, bus.fwd1, bus.wb_valid); end
    bus.src0 = 5'd5;
    #1;
    checks++; if (bus.fwd0 !== 32'hAAAA || bus.pend0 !== 1'b0) begin errors++; $display("FAIL flush_adv_ignored got %h/%b exp aaaa/0", bus.fwd0, bus.pend0); end
    bus.src0 = 5'd7;
    enter(5'd7, 1'b1, 32'h70, 2'd0);
    step();
    checks++; if (bus.fwd0 !== 32'h70) begin errors++; $display("FAIL refill_fwd got %h exp 70", bus.fwd0); end
    reset = 1'b0;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    step();
    idle();
    #1;
    checks++; if (bus.fwd0 !== 32'hAAAA || bus.pend0 !== 1'b0 || bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL midreset got %h/%b/%b exp aaaa/0/0", bus.fwd0, bus.pend0, bus.wb_valid); end
    reset = 1'b1;
    step();
  endtask

  initial begin
    idle();
    bus.src0 = '0; bus.src1 = '0; bus.rd0 = '0; bus.rd1 = '0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_link_youngest();
    test_zero_hold();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
